// File: rtl/deadtime_if.sv
// Command/config/gate-drive bundle for one half-bridge phase of deadtime_output_driver.
// Fault signals exist only when DEADTIME_DRIVER_FAULT_EN is defined.
interface deadtime_if;
  logic        enable;
  logic        cmd_in;
  logic [31:0] deadtime_in;
  logic [31:0] min_on_in;
  logic        load_cfg;
  logic        out_hi;
  logic        out_lo;
  logic        out_hi_n;
  logic        out_lo_n;
  logic        busy;
`ifdef DEADTIME_DRIVER_FAULT_EN
  logic        fault_in;
  logic        fault_clr;
  logic        fault_latched;
`endif

  modport slave (
`ifdef DEADTIME_DRIVER_FAULT_EN
    input  fault_in,
    input  fault_clr,
    output fault_latched,
`endif
    input  enable,
    input  cmd_in,
    input  deadtime_in,
    input  min_on_in,
    input  load_cfg,
    output out_hi,
    output out_lo,
    output out_hi_n,
    output out_lo_n,
    output busy
  );

  modport master (
`ifdef DEADTIME_DRIVER_FAULT_EN
    output fault_in,
    output fault_clr,
    input  fault_latched,
`endif
    output enable,
    output cmd_in,
    output deadtime_in,
    output min_on_in,
    output load_cfg,
    input  out_hi,
    input  out_lo,
    input  out_hi_n,
    input  out_lo_n,
    input  busy
  );
endinterface

// File: rtl/deadtime_output_driver.sv
// Complementary gate driver with programmable dead time and minimum on-time.
// Optional fault latch enabled by defining DEADTIME_DRIVER_FAULT_EN.
module deadtime_output_driver #(
  parameter logic [31:0] DEFAULT_DEADTIME = 32'd100,
  parameter logic [31:0] DEFAULT_MIN_ON   = 32'd0
) (
  input logic       clk,
  input logic       reset,
  deadtime_if.slave bus
);

  typedef enum logic [1:0] {StOff, StDt, StHi, StLo} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] dt_q, mo_q;
  logic [31:0] dt_eff, mo_eff;
  logic        out_hi_q, out_lo_q, busy_q;
  logic        fault_block;

  assign dt_eff = (dt_q == 32'd0) ? 32'd1 : dt_q;
  assign mo_eff = (mo_q == 32'd0) ? 32'd1 : mo_q;

`ifdef DEADTIME_DRIVER_FAULT_EN
  logic fault_q, fault_d;

  // A new fault beats a simultaneous clear; the clearing cycle itself still holds OFF.
  always_comb begin
    fault_d = fault_q;
    if (bus.fault_in) begin
      fault_d = 1'b1;
    end else if (bus.fault_clr) begin
      fault_d = 1'b0;
    end
  end

  assign fault_block       = bus.fault_in | fault_q;
  assign bus.fault_latched = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign fault_block = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fault_block || !bus.enable) begin
      state_d = StOff;
      cnt_d   = 32'd0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StDt;
          cnt_d   = 32'd1;
        end
        StDt: begin
          if (cnt_q >= dt_eff) begin
            state_d = bus.cmd_in ? StHi : StLo;
            cnt_d   = 32'd1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StHi, StLo: begin
          // Command is only looked at once the minimum on-time has elapsed.
          if ((bus.cmd_in == (state_q == StLo)) && (cnt_q >= mo_eff)) begin
            state_d = StDt;
            cnt_d   = 32'd1;
          end else begin
            cnt_d = (cnt_q >= mo_eff) ? mo_eff : cnt_q + 32'd1;
          end
        end
        default: begin
          state_d = StOff;
          cnt_d   = 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StOff;
      cnt_q    <= 32'd0;
      dt_q     <= DEFAULT_DEADTIME;
      mo_q     <= DEFAULT_MIN_ON;
      out_hi_q <= 1'b0;
      out_lo_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_hi_q <= (state_d == StHi);
      out_lo_q <= (state_d == StLo);
      busy_q   <= (state_d == StDt);
      if (bus.load_cfg) begin
        dt_q <= bus.deadtime_in;
        mo_q <= bus.min_on_in;
      end
    end
  end

  assign bus.out_hi   = out_hi_q;
  assign bus.out_lo   = out_lo_q;
  assign bus.out_hi_n = ~out_hi_q;
  assign bus.out_lo_n = ~out_lo_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_deadtime_output_driver.sv
// Bench for deadtime_output_driver: directed timing checks plus randomized traffic
// compared every cycle against a phase/elapsed-time reference model.
module tb_deadtime_output_driver;

  localparam logic [31:0] DefDt = 32'd100;
  localparam logic [31:0] DefMo = 32'd0;
  localparam int MOff = 0;
  localparam int MGap = 1;
  localparam int MHi  = 2;
  localparam int MLo  = 3;

  logic clk = 1'b0;
  logic reset;
  deadtime_if bus ();

  deadtime_output_driver #(
    .DEFAULT_DEADTIME(DefDt),
    .DEFAULT_MIN_ON  (DefMo)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     m_phase;
  longint m_time;
  longint m_dt, m_mo;
  bit     m_fault;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Phase model: off, gap (both off), high, low; m_time is time spent in the phase.
  task automatic model_step();
    longint dte, moe;
    bit     halted;
    bit     leave;
    dte    = (m_dt == 0) ? 1 : m_dt;
    moe    = (m_mo == 0) ? 1 : m_mo;
    halted = !bus.enable;
    if (reset) begin
      m_phase = MOff;
      m_time  = 0;
      m_dt    = DefDt;
      m_mo    = DefMo;
      m_fault = 0;
    end else begin
`ifdef DEADTIME_DRIVER_FAULT_EN
      if (bus.fault_in) begin
        m_fault = 1;
        halted  = 1;
      end else if (m_fault) begin
        halted = 1;
        if (bus.fault_clr) m_fault = 0;
      end
`endif
      if (halted) begin
        m_phase = MOff;
        m_time  = 0;
      end else if (m_phase == MOff) begin
        m_phase = MGap;
        m_time  = 1;
      end else if (m_phase == MGap) begin
        if (m_time >= dte) begin
          m_phase = bus.cmd_in ? MHi : MLo;
          m_time  = 1;
        end else begin
          m_time = m_time + 1;
        end
      end else begin
        leave = (m_phase == MHi) ? !bus.cmd_in : bus.cmd_in;
        if (leave && m_time >= moe) begin
          m_phase = MGap;
          m_time  = 1;
        end else begin
          m_time = (m_time + 1 > moe) ? moe : m_time + 1;
        end
      end
      if (bus.load_cfg) begin
        m_dt = bus.deadtime_in;
        m_mo = bus.min_on_in;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_eq("out_hi", bus.out_hi, (m_phase == MHi));
    check_eq("out_lo", bus.out_lo, (m_phase == MLo));
    check_eq("out_hi_n", bus.out_hi_n, (m_phase != MHi));
    check_eq("out_lo_n", bus.out_lo_n, (m_phase != MLo));
    check_eq("busy", bus.busy, (m_phase == MGap));
    check_eq("no_overlap", bus.out_hi & bus.out_lo, 0);
`ifdef DEADTIME_DRIVER_FAULT_EN
    check_eq("fault_latched", bus.fault_latched, m_fault);
`endif
  endtask

  task automatic wait_for(input bit lo_side, input logic want, input int limit, output int n);
    n = 0;
    while (((lo_side ? bus.out_lo : bus.out_hi) !== want) && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic load(input logic [31:0] dt, input logic [31:0] mo);
    bus.deadtime_in = dt;
    bus.min_on_in   = mo;
    bus.load_cfg    = 1'b1;
    step();
    bus.load_cfg = 1'b0;
  endtask

  initial begin
    int n;
    reset           = 1'b1;
    bus.enable      = 1'b0;
    bus.cmd_in      = 1'b0;
    bus.deadtime_in = '0;
    bus.min_on_in   = '0;
    bus.load_cfg    = 1'b0;
`ifdef DEADTIME_DRIVER_FAULT_EN
    bus.fault_in  = 1'b0;
    bus.fault_clr = 1'b0;
`endif
    m_phase = MOff;
    m_time  = 0;
    m_dt    = DefDt;
    m_mo    = DefMo;
    m_fault = 0;
    repeat (3) step();
    reset = 1'b0;

    // Reset defaults: high side after 100 both-off cycles
    bus.enable = 1'b1;
    bus.cmd_in = 1'b1;
    step();
    check_eq("dflt_busy_first", bus.busy, 1);
    wait_for(0, 1'b1, 300, n);
    check_eq("dflt_hi_delay", n, 100);

    // Disable mid-gap, re-enable gets a full dead time
    bus.cmd_in = 1'b0;
    step();
    check_eq("dflt_hi_drop", bus.out_hi, 0);
    repeat (10) step();
    bus.enable = 1'b0;
    step();
    check_eq("disable_busy", bus.busy, 0);
    bus.enable = 1'b1;
    step();
    wait_for(1, 1'b1, 300, n);
    check_eq("reenable_full_dt", n, 100);

    // Reset while low side on; config returns to defaults
    load(32'd2, 32'd2);
    reset = 1'b1;
    step();
    check_eq("reset_drops_lo", bus.out_lo, 0);
    reset = 1'b0;
    step();
    wait_for(1, 1'b1, 300, n);
    check_eq("reset_restores_dt", n, 100);

    // Dead time of 5
    bus.enable = 1'b0;
    load(32'd5, 32'd0);
    bus.enable = 1'b1;
    bus.cmd_in = 1'b1;
    wait_for(0, 1'b1, 50, n);
    check_eq("dt5_hi_reach", bus.out_hi, 1);
    bus.cmd_in = 1'b0;
    step();
    check_eq("dt5_hi_drop", bus.out_hi, 0);
    wait_for(1, 1'b1, 50, n);
    check_eq("dt5_lo_rise", n, 5);

    // Minimum on-time 20, dead time 3, early command change ignored
    bus.enable = 1'b0;
    load(32'd3, 32'd20);
    bus.enable = 1'b1;
    bus.cmd_in = 1'b1;
    wait_for(0, 1'b1, 50, n);
    check_eq("mo_hi_reach", bus.out_hi, 1);
    repeat (3) step();
    bus.cmd_in = 1'b0;
    wait_for(0, 1'b0, 50, n);
    check_eq("mo_hi_hold", n + 3, 20);
    wait_for(1, 1'b1, 50, n);
    check_eq("mo_lo_rise", n, 3);

    // Zero config, command toggling every cycle
    load(32'd0, 32'd0);
    for (int i = 0; i < 200; i++) begin
      bus.cmd_in = ~bus.cmd_in;
      step();
    end

`ifdef DEADTIME_DRIVER_FAULT_EN
    // Fault latch overrides enable until cleared
    load(32'd2, 32'd0);
    bus.cmd_in = 1'b1;
    wait_for(0, 1'b1, 50, n);
    bus.fault_in = 1'b1;
    step();
    bus.fault_in = 1'b0;
    check_eq("fault_hi_off", bus.out_hi, 0);
    check_eq("fault_set", bus.fault_latched, 1);
    for (int i = 0; i < 6; i++) begin
      bus.enable = i[0];
      step();
    end
    bus.enable    = 1'b1;
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    check_eq("fault_clear", bus.fault_latched, 0);
    wait_for(0, 1'b1, 50, n);
    check_eq("fault_resume", n, 3);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.load_cfg    = ($urandom_range(0, 19) == 0);
      bus.deadtime_in = $urandom_range(0, 6);
      bus.min_on_in   = $urandom_range(0, 8);
      if ($urandom_range(0, 3) == 0) bus.cmd_in = ~bus.cmd_in;
      bus.enable = ($urandom_range(0, 59) != 0);
      reset      = ($urandom_range(0, 399) == 0);
`ifdef DEADTIME_DRIVER_FAULT_EN
      bus.fault_in  = ($urandom_range(0, 199) == 0);
      bus.fault_clr = ($urandom_range(0, 9) == 0);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
